// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, the shared memory port
// and the arbiter status outputs.
// slave  : arbiter view (takes requests, drives the memory port).
// master : environment view (requesters plus memory model).
interface mem_arbiter_if;
  logic        r0_cen;
  logic        r0_wen;
  logic [31:0] r0_addr;
  logic [7:0]  r0_wdata;
  logic        r0_lock;
  logic        r0_ack;
  logic [7:0]  r0_rdata;

  logic        r1_cen;
  logic        r1_wen;
  logic [31:0] r1_addr;
  logic [7:0]  r1_wdata;
  logic        r1_lock;
  logic        r1_ack;
  logic [7:0]  r1_rdata;

  logic        mem_cen;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        busy;
  logic [1:0]  grant;

  modport slave (
    input  r0_cen, r0_wen, r0_addr, r0_wdata, r0_lock,
    input  r1_cen, r1_wen, r1_addr, r1_wdata, r1_lock,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output mem_cen, mem_wen, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy, grant
  );

  modport master (
    output r0_cen, r0_wen, r0_addr, r0_wdata, r0_lock,
    output r1_cen, r1_wen, r1_addr, r1_wdata, r1_lock,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  mem_cen, mem_wen, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy, grant
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single
// memory port, one access in flight (IDLE -> BUSY -> RESP).
// Optional burst lock is compiled in with `define MEM_ARB_LOCK_EN: a locked
// owner keeps the port for up to LOCK_MAX consecutive grants.
// Reset (aresetn) is synchronous, active-low.
module mem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input logic          clk,
  input logic          aresetn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [1:0]  grant_reg, grant_next;
  logic        wen_reg, wen_next;
  logic [31:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;

  // Requester fields gathered into vectors so selection is a plain index.
  logic [1:0]  cen_vec;
  logic [1:0]  wen_vec;
  logic [1:0]  lock_vec;
  logic [31:0] addr_vec [2];
  logic [7:0]  wdata_vec [2];
  logic [1:0]  ack_vec;

  logic [1:0]  eligible;
  logic        pick;
  logic        hold_eff;

  assign cen_vec      = {bus.r1_cen, bus.r0_cen};
  assign wen_vec      = {bus.r1_wen, bus.r0_wen};
  assign lock_vec     = {bus.r1_lock, bus.r0_lock};
  assign addr_vec[0]  = bus.r0_addr;
  assign addr_vec[1]  = bus.r1_addr;
  assign wdata_vec[0] = bus.r0_wdata;
  assign wdata_vec[1] = bus.r1_wdata;

`ifdef MEM_ARB_LOCK_EN
  localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

  // hold_reg: previous owner asked to keep the port; lock_cnt_reg counts its
  // consecutive grants. The hold is void as soon as the owner drops its lock.
  logic       hold_reg, hold_next;
  logic [7:0] lock_cnt_reg, lock_cnt_next;

  assign hold_eff = hold_reg & lock_vec[owner_reg];
`else
  logic unused_lock;

  assign hold_eff    = 1'b0;
  assign unused_lock = ^lock_vec;
`endif

  // Next-state, arbitration and captured-request logic.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    grant_next = grant_reg;
    wen_next   = wen_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
`ifdef MEM_ARB_LOCK_EN
    hold_next     = hold_reg;
    lock_cnt_next = lock_cnt_reg;
`endif
    // During a lock hold only the current owner (still in grant_reg) competes.
    eligible = hold_eff ? (cen_vec & grant_reg) : cen_vec;
    // Contention goes to the requester that was not granted last.
    pick     = (eligible == 2'b11) ? ~last_reg : eligible[1];

    case (state_reg)
      IDLE: begin
        if (eligible != 2'b00) begin
          state_next = BUSY;
          owner_next = pick;
          wen_next   = wen_vec[pick];
          addr_next  = addr_vec[pick];
          wdata_next = wdata_vec[pick];
          grant_next = pick ? 2'b10 : 2'b01;
`ifdef MEM_ARB_LOCK_EN
          hold_next = 1'b0;
          if (!lock_vec[pick])
            lock_cnt_next = 8'd0;
          else if (hold_eff)
            lock_cnt_next = lock_cnt_reg + 8'd1;
          else
            lock_cnt_next = 8'd1;
`endif
        end else begin
          grant_next = hold_eff ? grant_reg : 2'b00;
`ifdef MEM_ARB_LOCK_EN
          if (!hold_eff) begin
            hold_next     = 1'b0;
            lock_cnt_next = 8'd0;
          end
`endif
        end
      end
      BUSY: begin
        if (bus.mem_ack)
          state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        last_next  = owner_reg;
        grant_next = 2'b00;
`ifdef MEM_ARB_LOCK_EN
        if (lock_vec[owner_reg] && (lock_cnt_reg < LOCK_LIMIT)) begin
          hold_next  = 1'b1;
          grant_next = grant_reg;
        end else begin
          hold_next     = 1'b0;
          lock_cnt_next = 8'd0;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      grant_reg <= 2'b00;
      wen_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      grant_reg <= grant_next;
      wen_reg   <= wen_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Lock hold flag and consecutive-grant counter.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      hold_reg     <= 1'b0;
      lock_cnt_reg <= 8'd0;
    end else begin
      hold_reg     <= hold_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end
`endif

  // Per-requester read-data holding register and ack decode; a requester's
  // data only changes when it owns the completing access.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [7:0] rdata_reg;

    // Capture memory read data on mem_ack for the owning requester.
    always_ff @(posedge clk) begin
      if (!aresetn)
        rdata_reg <= 8'd0;
      else if ((state_reg == BUSY) && bus.mem_ack && (owner_reg == 1'(gi)))
        rdata_reg <= bus.mem_rdata;
    end

    assign ack_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
  end

  assign bus.r0_ack    = ack_vec[0];
  assign bus.r1_ack    = ack_vec[1];
  assign bus.r0_rdata  = g_req[0].rdata_reg;
  assign bus.r1_rdata  = g_req[1].rdata_reg;

  assign bus.mem_cen   = (state_reg == BUSY);
  assign bus.mem_wen   = (state_reg == BUSY) & wen_reg;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;

  assign bus.busy      = (state_reg != IDLE);
  assign bus.grant     = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: single read latency, write with a
// requester field change mid-access, reset mid-access with a late mem_ack,
// round-robin contention and burst lock behaviour (follows MEM_ARB_LOCK_EN).
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;

  // Memory model: acknowledges one cycle after it first sees mem_cen.
  logic       model_ack = 1'b0;
  logic       manual_ack = 1'b0;
  logic       mem_auto = 1'b1;
  logic       preloaded = 1'b0;
  logic [7:0] model_rdata = 8'd0;
  logic [7:0] mem_model [0:1023];

  assign bus.mem_ack   = model_ack | manual_ack;
  assign bus.mem_rdata = model_rdata;

  // Memory model process.
  always @(posedge clk) begin
    if (!preloaded) begin
      mem_model[10'h010] <= 8'h5A;
      preloaded <= 1'b1;
    end
    model_ack <= 1'b0;
    if (mem_auto && bus.mem_cen && !model_ack) begin
      model_ack <= 1'b1;
      if (bus.mem_wen)
        mem_model[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else
        model_rdata <= mem_model[bus.mem_addr[9:0]];
    end
  end

`ifdef MEM_ARB_LOCK_EN
  localparam logic [7:0] LOCK_SEQ = 8'b0001_0000;
`else
  localparam logic [7:0] LOCK_SEQ = 8'b0000_1010;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_vals(input string pfx);
    chk({pfx, "_mem_cen"},   32'(bus.mem_cen),   32'd0);
    chk({pfx, "_mem_wen"},   32'(bus.mem_wen),   32'd0);
    chk({pfx, "_mem_addr"},  bus.mem_addr,       32'd0);
    chk({pfx, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({pfx, "_r0_ack"},    32'(bus.r0_ack),    32'd0);
    chk({pfx, "_r1_ack"},    32'(bus.r1_ack),    32'd0);
    chk({pfx, "_r0_rdata"},  32'(bus.r0_rdata),  32'd0);
    chk({pfx, "_r1_rdata"},  32'(bus.r1_rdata),  32'd0);
    chk({pfx, "_grant"},     32'(bus.grant),     32'd0);
    chk({pfx, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  // Collect n completions with both requesters asserted; exp_seq bit k is the
  // expected owner of the k-th completion.
  task automatic collect(input string tag, input int n, input logic [7:0] exp_seq);
    int  k = 0;
    int  both = 0;
    bit  seen_r0 = 1'b0;
    for (int c = 0; c < 30 * n && k < n; c++) begin
      @(negedge clk);
      if (bus.r0_ack && bus.r1_ack)
        both++;
      if (bus.r0_ack) begin
        chk($sformatf("%s_order%0d", tag, k), 32'd0, 32'(exp_seq[k]));
        chk($sformatf("%s_r0_rdata%0d", tag, k), 32'(bus.r0_rdata), 32'h5A);
        $display("txn %s #%0d owner=r0 rdata=%02h", tag, k, bus.r0_rdata);
        seen_r0 = 1'b1;
        k++;
      end else if (bus.r1_ack) begin
        chk($sformatf("%s_order%0d", tag, k), 32'd1, 32'(exp_seq[k]));
        chk($sformatf("%s_r1_rdata%0d", tag, k), 32'(bus.r1_rdata), 32'hC3);
        if (seen_r0)
          chk($sformatf("%s_r0_hold%0d", tag, k), 32'(bus.r0_rdata), 32'h5A);
        $display("txn %s #%0d owner=r1 rdata=%02h", tag, k, bus.r1_rdata);
        k++;
      end
    end
    bus.r0_cen = 1'b0;
    bus.r1_cen = 1'b0;
    chk({tag, "_count"}, 32'(k), 32'(n));
    chk({tag, "_both_ack"}, 32'(both), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Single access by one requester, bounded wait for its ack.
  task automatic access(input bit who, input bit wr, input logic [31:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    bit got = 1'b0;
    logic [7:0] rd;
    if (who) begin
      bus.r1_wen = wr; bus.r1_addr = a; bus.r1_wdata = d; bus.r1_cen = 1'b1;
    end else begin
      bus.r0_wen = wr; bus.r0_addr = a; bus.r0_wdata = d; bus.r0_cen = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = who ? bus.r1_ack : bus.r0_ack;
    end
    rd = who ? bus.r1_rdata : bus.r0_rdata;
    chk($sformatf("acc_r%0d_ack", who), 32'(got), 32'd1);
    if (!wr)
      chk($sformatf("acc_r%0d_rdata", who), 32'(rd), 32'(exp));
    $display("txn r%0d %s addr=%08h data=%02h", who, wr ? "write" : "read", a, wr ? d : rd);
    bus.r0_cen = 1'b0;
    bus.r1_cen = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.r0_cen = 1'b0; bus.r0_wen = 1'b0; bus.r0_addr = 32'd0; bus.r0_wdata = 8'd0; bus.r0_lock = 1'b0;
    bus.r1_cen = 1'b0; bus.r1_wen = 1'b0; bus.r1_addr = 32'd0; bus.r1_wdata = 8'd0; bus.r1_lock = 1'b0;

    // Reset state.
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    aresetn = 1'b1;
    @(negedge clk);

    // r0 read of 0x10: mem_cen at T+1, mem_ack at T+2, r0_ack at T+3.
    bus.r0_wen = 1'b0; bus.r0_addr = 32'h0000_0010; bus.r0_cen = 1'b1;
    @(negedge clk);
    chk("rd_t1_mem_cen", 32'(bus.mem_cen), 32'd1);
    chk("rd_t1_grant",   32'(bus.grant),   32'd1);
    chk("rd_t1_busy",    32'(bus.busy),    32'd1);
    chk("rd_t1_addr",    bus.mem_addr,     32'h10);
    chk("rd_t1_wen",     32'(bus.mem_wen), 32'd0);
    chk("rd_t1_ack",     32'(bus.r0_ack),  32'd0);
    @(negedge clk);
    chk("rd_t2_ack",     32'(bus.r0_ack),  32'd0);
    chk("rd_t2_mem_cen", 32'(bus.mem_cen), 32'd1);
    @(negedge clk);
    chk("rd_t3_ack",     32'(bus.r0_ack),   32'd1);
    chk("rd_t3_rdata",   32'(bus.r0_rdata), 32'h5A);
    chk("rd_t3_mem_cen", 32'(bus.mem_cen),  32'd0);
    chk("rd_t3_busy",    32'(bus.busy),     32'd1);
    chk("rd_t3_r1_ack",  32'(bus.r1_ack),   32'd0);
    $display("txn r0 read addr=00000010 data=%02h", bus.r0_rdata);
    bus.r0_cen = 1'b0;
    @(negedge clk);
    chk("rd_t4_ack",   32'(bus.r0_ack), 32'd0);
    chk("rd_t4_busy",  32'(bus.busy),   32'd0);
    chk("rd_t4_grant", 32'(bus.grant),  32'd0);

    // r1 write 0xC3 to 0x3FF, requester fields change while BUSY.
    bus.r1_wen = 1'b1; bus.r1_addr = 32'h0000_03FF; bus.r1_wdata = 8'hC3; bus.r1_cen = 1'b1;
    @(negedge clk);
    chk("wr_mem_cen",   32'(bus.mem_cen),   32'd1);
    chk("wr_mem_wen",   32'(bus.mem_wen),   32'd1);
    chk("wr_mem_addr",  bus.mem_addr,       32'h3FF);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'hC3);
    chk("wr_grant",     32'(bus.grant),     32'd2);
    bus.r1_addr = 32'd0; bus.r1_wdata = 8'd0; bus.r1_wen = 1'b0;
    @(negedge clk);
    chk("wr_addr_held",  bus.mem_addr,       32'h3FF);
    chk("wr_wdata_held", 32'(bus.mem_wdata), 32'hC3);
    chk("wr_wen_held",   32'(bus.mem_wen),   32'd1);
    @(negedge clk);
    chk("wr_ack",    32'(bus.r1_ack), 32'd1);
    chk("wr_r0_ack", 32'(bus.r0_ack), 32'd0);
    $display("txn r1 write addr=000003ff data=c3");
    bus.r1_cen = 1'b0;
    @(negedge clk);
    chk("wr_mem_model", 32'(mem_model[10'h3FF]), 32'hC3);
    access(1'b1, 1'b0, 32'h0000_03FF, 8'h00, 8'hC3);
    chk("wr_r0_rdata_hold", 32'(bus.r0_rdata), 32'h5A);

    // Reset during BUSY, mem_ack arriving the cycle after reset.
    mem_auto = 1'b0;
    bus.r0_wen = 1'b0; bus.r0_addr = 32'h0000_0010; bus.r0_cen = 1'b1;
    @(negedge clk);
    chk("mid_busy_mem_cen", 32'(bus.mem_cen), 32'd1);
    aresetn = 1'b0;
    bus.r0_cen = 1'b0;
    @(negedge clk);
    reset_vals("mid");
    aresetn = 1'b1;
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    chk("mid_late_r0_ack", 32'(bus.r0_ack), 32'd0);
    chk("mid_late_busy",   32'(bus.busy),   32'd0);
    @(negedge clk);
    chk("mid_after_r0_ack",  32'(bus.r0_ack),  32'd0);
    chk("mid_after_mem_cen", 32'(bus.mem_cen), 32'd0);
    chk("mid_after_busy",    32'(bus.busy),    32'd0);
    mem_auto = 1'b1;
    @(negedge clk);

    // Contention from reset: r0, r1, r0, r1.
    bus.r0_wen = 1'b0; bus.r0_addr = 32'h0000_0010; bus.r0_cen = 1'b1;
    bus.r1_wen = 1'b0; bus.r1_addr = 32'h0000_03FF; bus.r1_cen = 1'b1;
    collect("rr", 4, 8'b0000_1010);

    // Burst lock: r0_lock held, both requesting, LOCK_MAX=4.
    aresetn = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    bus.r0_lock = 1'b1;
    bus.r0_wen = 1'b0; bus.r0_addr = 32'h0000_0010; bus.r0_cen = 1'b1;
    bus.r1_wen = 1'b0; bus.r1_addr = 32'h0000_03FF; bus.r1_cen = 1'b1;
    collect("lock", 5, LOCK_SEQ);
    bus.r0_lock = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
